// File: rtl/pipo.sv
// pipo: parallel-in, parallel-out holding register.
//
// Captures the whole input word on every rising edge of clk and drives it
// on o until the next edge. Acts as a one-cycle pipeline stage between
// datapath blocks. There is no enable, no shifting and no handshake.
//
// Ports (declaration order is fixed because callers connect by position):
//   o    out  WIDTH  registered data out, driven straight from the flops
//   clk  in   1      system clock, rising-edge active
//   rst  in   1      synchronous active-high reset, loads RESET_VALUE
//   i    in   WIDTH  parallel data in
//
// Parameters:
//   WIDTH        data width (default 4)
//   RESET_VALUE  value loaded into o while rst is high (default all zeros)
module pipo #(
  parameter int unsigned       WIDTH       = 4,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  output logic [WIDTH-1:0] o,
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i
);

  // Reset takes priority over the data input at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      o <= RESET_VALUE;
    end else begin
      o <= i;
    end
  end

endmodule

// File: tb/tb_pipo.sv
// tb_pipo: self-checking bench for pipo.
//
// Runs a default 4-bit instance and an 8-bit instance with a non-zero reset
// value side by side. Expected outputs come from a one-line behavioural
// model: after an edge, o is the reset value if rst was high at that edge,
// otherwise the input word present at that edge. Between edges o must hold.
module tb_pipo;

  logic       clk;
  logic       rst;
  logic [3:0] i;
  logic [3:0] o;

  logic       rst8;
  logic [7:0] i8;
  logic [7:0] o8;

  int unsigned n_vec;
  int unsigned n_bad;

  logic [3:0] exp4;
  logic [7:0] exp8;

  pipo u_dut (
    .o  (o),
    .clk(clk),
    .rst(rst),
    .i  (i)
  );

  pipo #(
    .WIDTH      (8),
    .RESET_VALUE(8'hA5)
  ) u_dut8 (
    .o  (o8),
    .clk(clk),
    .rst(rst8),
    .i  (i8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at t=%0t", tag, got, want, $time);
    end
  endtask

  // One clock: drive at the falling edge, confirm o held, then check the
  // value captured at the following rising edge against the model.
  task automatic cycle(input string tag, input logic r, input logic [3:0] a,
                       input logic r8, input logic [7:0] a8);
    @(negedge clk);
    rst  = r;
    i    = a;
    rst8 = r8;
    i8   = a8;
    #1;
    check({tag, "_hold"}, {4'h0, o}, {4'h0, exp4});
    check({tag, "_hold8"}, o8, exp8);
    @(posedge clk);
    #1;
    exp4 = r  ? 4'h0  : a;
    exp8 = r8 ? 8'hA5 : a8;
    check(tag, {4'h0, o}, {4'h0, exp4});
    check({tag, "_w8"}, o8, exp8);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    // Reset across the first rising edge (t = 5).
    rst  = 1'b1;
    i    = 4'($urandom);
    rst8 = 1'b1;
    i8   = 8'($urandom);
    @(posedge clk);
    #1;
    exp4 = 4'h0;
    exp8 = 8'hA5;
    check("reset", {4'h0, o}, 8'h00);
    check("reset_w8", o8, 8'hA5);

    // First edge out of reset loads the input; 8-bit instance takes 8'h3C.
    cycle("load_0", 1'b0, 4'h0, 1'b0, 8'h3C);
    check("param_3c", o8, 8'h3C);

    // Every 4-bit code, one clock behind i.
    for (int v = 1; v < 16; v++) begin
      cycle("seq", 1'b0, 4'(v), 1'b0, 8'($urandom));
    end

    // Hold between edges: 5 then 6 changed on the falling edge.
    cycle("hold_5", 1'b0, 4'h5, 1'b0, 8'($urandom));
    cycle("hold_6", 1'b0, 4'h6, 1'b0, 8'($urandom));

    // Synchronous reset raised mid-cycle while o = 1010; o holds until the edge.
    cycle("pre_a", 1'b0, 4'hA, 1'b0, 8'h5A);
    cycle("sync_rst", 1'b1, 4'($urandom), 1'b1, 8'($urandom));
    check("sync_rst_zero", {4'h0, o}, 8'h00);
    cycle("rst_drop", 1'b0, 4'h7, 1'b0, 8'h77);
    check("rst_drop_7", {4'h0, o}, 8'h07);

    // Reset priority over an all-ones input for two edges.
    cycle("prio_1", 1'b1, 4'hF, 1'b1, 8'hFF);
    cycle("prio_2", 1'b1, 4'hF, 1'b1, 8'hFF);
    check("prio_zero", {4'h0, o}, 8'h00);
    check("prio_a5", o8, 8'hA5);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 300; n++) begin
      cycle("rand", ($urandom_range(0, 7) == 0), 4'($urandom),
            ($urandom_range(0, 7) == 0), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipo.md
Name: pipo

Overview:
- Parallel-in, parallel-out register of parameterised width, 4 bits by default.
- On every rising clock edge it captures the full input word and presents it on the output.
- Used as a one-cycle pipeline or holding stage between datapath blocks.
- No shifting, no enable and no handshake: it loads every cycle unless reset is asserted.

Parameters:
- WIDTH, 4, bit width of the data input and output.
- RESET_VALUE, 0 (WIDTH bits), value loaded into the output on reset.

Ports:
- Positional connection order is fixed as o, clk, rst, i. Instantiations connect by position, so the declaration order must match exactly.
- The list below gives ports clock and reset first, in logical order.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset. Synchronous, active-high. Sampled only at the rising edge of clk.
- i  input  WIDTH  parallel data in.
- o  output  WIDTH  parallel data out; registered, driven directly from the storage flops.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high. No asynchronous reset path exists.
- Storage: one WIDTH-bit register that drives o directly. There is no combinational path from i to o.
- At each rising edge of clk:
  - if rst = 1: o <= RESET_VALUE (all zeros by default);
  - else: o <= i.
- Latency: exactly one clock. A value present on i at rising edge N appears on o immediately after edge N and holds until edge N+1.
- Between edges, o is stable regardless of activity on i.
- Reset priority: when rst = 1 at an edge, i is ignored for that edge.
- Reset deassertion: on the first edge with rst = 0, the register loads i.
- Reset mid-operation: asserting rst for one edge clears o at that edge. Loading resumes on the next edge where rst = 0.
- Power-up: before the first reset edge, o is undefined (X in simulation). No initial value is required.
- If i is undefined (X/Z) at a load edge, o becomes X for that cycle. The register performs no checking or sanitising.
- Width rule: i and o have the same width. There is no truncation, extension or arithmetic. All bits are loaded independently, including MSB = 1 values such as 4'b1000 through 4'b1111.
- No other outputs, status flags or internal state.

Test Plan:
- Reset: clk period 10, rst = 1 across the first rising edge (t = 5) -> o = 4'b0000 after that edge.
- Sequential load: rst = 0, drive i = 0, 1, 2 ... 15, changing each value midway between rising edges -> after each following edge, o equals the value just applied. Check every code 4'b0000 through 4'b1111, one clock behind i.
- Hold between edges: change i on the falling edge (e.g. i goes 5 -> 6 at the falling edge) -> o stays 4'b0101 until the next rising edge, then becomes 4'b0110.
- Synchronous reset check: raise rst midway between edges while o = 4'b1010 -> o remains 4'b1010 until the next rising edge, then becomes 4'b0000. Drop rst with i = 4'b0111 -> o = 4'b0111 one edge later.
- Reset priority: rst = 1 with i = 4'b1111 held for two edges -> o = 4'b0000 throughout.
- Parameter check: WIDTH = 8, RESET_VALUE = 8'hA5 -> o = 8'hA5 after reset; after one edge with i = 8'h3C, o = 8'h3C.
